// File: rtl/fetch_queue_pkg.sv
// Shared types and helpers for the instruction prefetch queue.
// The top module fetch_queue honours the optional FETCH_QUEUE_BYPASS_EN macro.
package fetch_queue_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fq_entry_t;

  function automatic logic [XLEN-1:0] fq_align(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Memory, redirect and decode-side signals of the prefetch stage.
// master = the fetch queue itself, slave = memory/EX/decode environment.
interface fetch_queue_if;
  import fetch_queue_pkg::*;

  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_instr;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            deq_valid;
  logic            deq_ready;
  logic [XLEN-1:0] deq_pc;
  logic [XLEN-1:0] deq_instr;

  modport master (
    output imem_addr, deq_valid, deq_pc, deq_instr,
    input  imem_instr, redirect_valid, redirect_pc, deq_ready
  );

  modport slave (
    input  imem_addr, deq_valid, deq_pc, deq_instr,
    output imem_instr, redirect_valid, redirect_pc, deq_ready
  );
endinterface

// File: rtl/fetch_queue_fifo.sv
// Circular buffer of {pc, instr} entries with push/pop/flush control.
// Head is read from registered storage, so it never depends on this cycle's inputs.
module fq_fifo
  import fetch_queue_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  fq_entry_t        wr_data,
  output fq_entry_t        head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  fq_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch stage: owns the fetch PC, queues fetched words, flushes on redirect.
// Define FETCH_QUEUE_BYPASS_EN to present the memory word directly when the queue is empty.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  fetch_queue_if.master   bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  fq_entry_t        fifo_head, fifo_wr_data;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full, fifo_empty;
  logic             deq_fire, push, pop;
  logic             bypass_hit, bypass_take;

`ifdef FETCH_QUEUE_BYPASS_EN
  // With an empty queue the live memory word is offered straight to decode.
  assign bypass_hit    = fifo_empty & ~bus.redirect_valid;
  assign bus.deq_valid = ~fifo_empty | bypass_hit;
  assign bus.deq_pc    = fifo_empty ? fetch_pc_q     : fifo_head.pc;
  assign bus.deq_instr = fifo_empty ? bus.imem_instr : fifo_head.instr;
`else
  assign bypass_hit    = 1'b0;
  assign bus.deq_valid = ~fifo_empty;
  assign bus.deq_pc    = fifo_head.pc;
  assign bus.deq_instr = fifo_head.instr;
`endif

  assign deq_fire    = bus.deq_valid & bus.deq_ready;
  assign bypass_take = bypass_hit & bus.deq_ready;
  assign pop         = deq_fire & ~bypass_hit & ~bus.redirect_valid;
  assign push        = ~bus.redirect_valid & (~fifo_full | deq_fire) & ~bypass_take;

  assign fifo_wr_data.pc    = fetch_pc_q;
  assign fifo_wr_data.instr = bus.imem_instr;
  assign bus.imem_addr      = fetch_pc_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (bus.redirect_valid) begin
      fetch_pc_d = fq_align(bus.redirect_pc);
    end else if (push || bypass_take) begin
      fetch_pc_d = fetch_pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) fetch_pc_q <= RESET_PC;
    else     fetch_pc_q <= fetch_pc_d;
  end

  fq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .flush   (bus.redirect_valid),
    .wr_data (fifo_wr_data),
    .head    (fifo_head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (default build, no bypass): reset, stall, full push+pop,
// redirect with alignment, PC wrap and mid-stream reset. Inputs change and outputs are sampled on negedge.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  fetch_queue_if bus();

  always #5 clk = ~clk;

  // Instruction memory model: word value derived from its address.
  assign bus.imem_instr = 32'h1000_0000 + bus.imem_addr;

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("check %-14s got %h", tag, got);
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.deq_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc);
    check({tag, "_valid"}, 32'(bus.deq_valid), 32'd1);
    check({tag, "_pc"}, bus.deq_pc, pc);
    check({tag, "_instr"}, bus.deq_instr, 32'h1000_0000 + pc);
  endtask

  logic [31:0] wrap_pcs [4];

  initial begin
    wrap_pcs = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    rst = 1'b1;
    bus.deq_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    tick();
    tick();

    // Reset state
    check("rst_valid", 32'(bus.deq_valid), 32'd0);
    check("rst_addr", bus.imem_addr, 32'h0);
    check("rst_count", 32'(dut.u_fifo.count_q), 32'd0);

    // 1: streaming, first entry one cycle after the push
    rst = 1'b0;
    bus.deq_ready = 1'b1;
    check("t1_bubble", 32'(bus.deq_valid), 32'd0);
    tick();
    for (int k = 0; k < 5; k++) begin
      check_head("t1", 32'(4 * k));
      tick();
    end

    // 2: decode stall for 10 cycles saturates the queue
    apply_reset();
    repeat (10) tick();
    check("t2_count", 32'(dut.u_fifo.count_q), 32'd4);
    check("t2_addr", bus.imem_addr, 32'h10);
    check_head("t2_head", 32'h0);

    // 3: one accepting cycle while full gives push+pop
    bus.deq_ready = 1'b1;
    tick();
    bus.deq_ready = 1'b0;
    check("t3_count", 32'(dut.u_fifo.count_q), 32'd4);
    check("t3_addr", bus.imem_addr, 32'h14);
    check_head("t3_head", 32'h4);
    tick();
    tick();
    check("t3_hold_addr", bus.imem_addr, 32'h14);

    // 2 (release): remaining entries come out in order, nothing lost
    bus.deq_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check_head("t2_rel", 32'(4 + 4 * k));
      tick();
    end

    // 4: redirect to unaligned target with 3 queued and deq firing
    apply_reset();
    repeat (3) tick();
    check("t4_count", 32'(dut.u_fifo.count_q), 32'd3);
    check("t4_addr", bus.imem_addr, 32'hC);
    bus.deq_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h203;
    tick();
    bus.redirect_valid = 1'b0;
    check("t4_flush_vld", 32'(bus.deq_valid), 32'd0);
    check("t4_flush_cnt", 32'(dut.u_fifo.count_q), 32'd0);
    check("t4_flush_addr", bus.imem_addr, 32'h200);
    tick();
    check_head("t4_first", 32'h200);
    tick();
    check_head("t4_second", 32'h204);

    // 5: PC wraps modulo 2^32
    bus.deq_ready = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFF8;
    tick();
    bus.redirect_valid = 1'b0;
    repeat (4) tick();
    check("t5_count", 32'(dut.u_fifo.count_q), 32'd4);
    check("t5_addr", bus.imem_addr, 32'h8);
    bus.deq_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check_head("t5_wrap", wrap_pcs[k]);
      tick();
    end

    // 6: reset mid-stream with 2 entries queued
    apply_reset();
    repeat (2) tick();
    check("t6_count", 32'(dut.u_fifo.count_q), 32'd2);
    check("t6_addr", bus.imem_addr, 32'h8);
    rst = 1'b1;
    tick();
    check("t6_rst_valid", 32'(bus.deq_valid), 32'd0);
    check("t6_rst_addr", bus.imem_addr, 32'h0);
    check("t6_rst_count", 32'(dut.u_fifo.count_q), 32'd0);
    rst = 1'b0;
    bus.deq_ready = 1'b1;
    tick();
    check_head("t6_resume", 32'h0);
    tick();
    check_head("t6_next", 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
